complex_op_sequencer: RTL
=========================

// Module: complex_op_sequencer
// PURPOSE
//  Command-driven complex-number ALU. Sits beside the 32x10 dual-port register memory: fetches operands A and B
//  via the memory address ports, computes ADD/SUB/MUL/CONJ, and writes the result back to a destination word.
//  Word format: {re[DATA_W-1:DATA_W/2], im[DATA_W/2-1:0]}, both halves signed two's complement.
// PARAMETERS
//  ADDR_W  5   memory address width (32 words)
//  DATA_W  10  word width; must be even; each half is DATA_W/2 bits (5), range [-16,15]
// PORTS
//  clk            in   1       rising-edge clock
//  reset          in   1       asynchronous, active-low reset
//  cmd_valid      in   1       command offered
//  cmd_ready      out  1       high only in IDLE; command accepted when cmd_valid & cmd_ready at clk edge
//  cmd_op         in   2       00 ADD, 01 SUB (A-B), 10 MUL, 11 CONJ (of A; B ignored)
//  cmd_src_a      in   ADDR_W  operand A address
//  cmd_src_b      in   ADDR_W  operand B address
//  cmd_dst        in   ADDR_W  result address
//  mem_address_A  out  ADDR_W  to memory address_A
//  mem_address_B  out  ADDR_W  to memory address_B
//  mem_data_A     out  DATA_W  to memory data_in_A
//  mem_data_B     out  DATA_W  to memory data_in_B
//  mem_write      out  1       to memory write
//  mem_q_A        in   DATA_W  from memory data_out_A (valid one cycle after address is presented)
//  mem_q_B        in   DATA_W  from memory data_out_B
//  result         out  DATA_W  last computed word, held until next write-back
//  overflow       out  1       saturation occurred in last operation, held with result
//  done           out  1       one-cycle pulse, high during the write-back cycle
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE; all outputs 0 except cmd_ready=1; operand/command latches cleared.
//  All outputs are registered or decoded from registered state only; no combinational path from cmd_* to outputs.
//  FSM: IDLE -> FETCH -> LATCH -> EXEC -> WRITE -> IDLE; MUL inserts MUL2 between EXEC and WRITE.
//   IDLE : cmd_ready=1; on accept latch op/src_a/src_b/dst, load mem_address_A/B <= src_a/src_b.
//   FETCH: addresses held; memory captures them at end of cycle.
//   LATCH: capture mem_q_A/mem_q_B into operand regs at end of cycle.
//   EXEC : ADD/SUB/CONJ compute final result; MUL computes re = ac - bd (full-width products).
//   MUL2 : MUL computes im = ad + bc.
//   WRITE: mem_write=1, mem_address_A=mem_address_B=dst, mem_data_A=mem_data_B=result; done=1. Next: IDLE.
//  Latency: accept edge -> write edge = 4 cycles (ADD/SUB/CONJ), 5 cycles (MUL); cmd_ready low throughout.
//  mem_write is 1 only in WRITE; outside WRITE mem_data_A/B hold last value and are don't-care to memory.
//  Arithmetic: each half computed at full precision (add/sub 6 b, mul products 10 b, sum 11 b), then
//   saturated to [-16,15]; overflow = OR of saturation on re and im. CONJ: re=a, im=-b (-(-16) -> 15, overflow=1).
//  MUL is integer (no fractional scaling).
//  Boundaries: dst may equal src_a/src_b (operands already latched; write-back safe). cmd_valid while busy
//   is ignored, not queued. Reset mid-operation aborts: no write issued, state IDLE, result/overflow cleared.
//  cmd_valid asserted in the cycle WRITE returns to IDLE is accepted on the following edge (no back-to-back bypass).
// TESTING (memory instance connected; words as hex {re,im})
//  1 mem[1]=0x062 (3+2i), mem[2]=0x03F (1-1i); ADD 1,2->3 -> done 4 cycles after accept; mem[3]=0x081 (4+1i), overflow=0.
//  2 same operands, MUL 1,2->4 -> done 5 cycles after accept; mem[4]=0x0BF (5-1i), overflow=0.
//  3 mem[5]=0x1E0 (15+0i); ADD 5,5->6 -> mem[6]=0x1E0 (saturated 15), overflow=1; SUB 5,5->7 -> mem[7]=0x000, overflow=0.
//  4 mem[8]=0x210 (-16-16i); CONJ 8,x->8 -> mem[8]=0x20F (-16+15i), overflow=1; in-place write verified.
//  5 cmd_valid held high continuously with 3 commands -> each accepted only when cmd_ready=1; no command lost or duplicated.
//  6 assert reset=0 during EXEC of a MUL -> mem_write never pulses, done=0, cmd_ready=1 after release, dst word unchanged.

Source files
------------

// File: rtl/complex_op_sequencer_if.sv
// Bus bundle between the complex-number sequencer and its environment
// (command issuer plus the 32x10 dual-port register memory).
//
// Command handshake: the issuer holds cmd_valid and the cmd_* fields
// stable. A command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both 1. cmd_ready depends only on sequencer state, never
// on cmd_valid, so a command offered while the sequencer is busy is just
// not taken. It is neither queued nor lost, and it stays offered until
// the issuer drops it.
//
// state_dbg mirrors the sequencer FSM encoding for observation only.
interface complex_op_sequencer_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 10
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [ADDR_W-1:0] cmd_src_a;
   logic [ADDR_W-1:0] cmd_src_b;
   logic [ADDR_W-1:0] cmd_dst;

   logic [ADDR_W-1:0] mem_address_A;
   logic [ADDR_W-1:0] mem_address_B;
   logic [DATA_W-1:0] mem_data_A;
   logic [DATA_W-1:0] mem_data_B;
   logic              mem_write;
   logic [DATA_W-1:0] mem_q_A;
   logic [DATA_W-1:0] mem_q_B;

   logic [DATA_W-1:0] result;
   logic              overflow;
   logic              done;
   logic [2:0]        state_dbg;

   // Environment side: issues commands and models the memory read ports
   modport master (
      output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst,
      output mem_q_A, mem_q_B,
      input  cmd_ready,
      input  mem_address_A, mem_address_B, mem_data_A, mem_data_B, mem_write,
      input  result, overflow, done, state_dbg
   );

   // Sequencer side
   modport slave (
      input  cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst,
      input  mem_q_A, mem_q_B,
      output cmd_ready,
      output mem_address_A, mem_address_B, mem_data_A, mem_data_B, mem_write,
      output result, overflow, done, state_dbg
   );
endinterface

// File: rtl/complex_op_sequencer.sv
// Command-driven complex-number ALU beside a dual-port register memory.
// It fetches operands A and B through the memory address ports and computes
// ADD, SUB, MUL or CONJ on {re, im} words made of signed halves. Each half of
// the result saturates on its own, and the result is written back to cmd_dst
// through both memory ports. Every output comes from a register or is
// decoded from the registered state, so no path runs from cmd_* to outputs.
module complex_op_sequencer #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 10
) (
   input logic                   clk,
   input logic                   reset,
   complex_op_sequencer_if.slave bus
);

   localparam int H    = DATA_W / 2;
   // Working width: holds a full-precision product sum (2*H+1 bits) with margin
   localparam int WIDE = DATA_W + 2;
   localparam int HMAX = (2 ** (H - 1)) - 1;
   localparam int HMIN = -(2 ** (H - 1));
   localparam logic signed [WIDE-1:0] SAT_MAX = WIDE'(HMAX);
   localparam logic signed [WIDE-1:0] SAT_MIN = WIDE'(HMIN);

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_MUL  = 2'b10;
   localparam logic [1:0] OP_CONJ = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LATCH = 3'd2,
      S_EXEC  = 3'd3,
      S_MUL2  = 3'd4,
      S_WRITE = 3'd5
   } state_t;

   // Clamp a full-precision half into H-bit range; MSB of the return is the saturation flag
   function automatic logic [H:0] sat_half(input logic signed [WIDE-1:0] v);
      logic [H:0] r;
      if (v > SAT_MAX) begin
         r = {1'b1, SAT_MAX[H-1:0]};
      end else if (v < SAT_MIN) begin
         r = {1'b1, SAT_MIN[H-1:0]};
      end else begin
         r = {1'b0, v[H-1:0]};
      end
      return r;
   endfunction

   state_t            state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [ADDR_W-1:0] addr_a_q, addr_a_d;
   logic [ADDR_W-1:0] addr_b_q, addr_b_d;
   logic [DATA_W-1:0] opa_q, opa_d;
   logic [DATA_W-1:0] opb_q, opb_d;
   logic [H-1:0]      mul_re_q, mul_re_d;
   logic              mul_ovf_q, mul_ovf_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              overflow_q, overflow_d;

   // Sign-extended operand halves
   logic signed [WIDE-1:0] a_re, a_im, b_re, b_im;
   assign a_re = {{(WIDE-H){opa_q[DATA_W-1]}}, opa_q[DATA_W-1:H]};
   assign a_im = {{(WIDE-H){opa_q[H-1]}},      opa_q[H-1:0]};
   assign b_re = {{(WIDE-H){opb_q[DATA_W-1]}}, opb_q[DATA_W-1:H]};
   assign b_im = {{(WIDE-H){opb_q[H-1]}},      opb_q[H-1:0]};

   logic signed [WIDE-1:0] raw_re, raw_im;
   logic [H:0]             sat_re, sat_im;

   // Full-precision per-half arithmetic for the latched op, then saturation.
   // For MUL, raw_re is consumed in EXEC and raw_im in MUL2.
   always_comb begin
      raw_re = '0;
      raw_im = '0;
      case (op_q)
         OP_ADD: begin
            raw_re = a_re + b_re;
            raw_im = a_im + b_im;
         end
         OP_SUB: begin
            raw_re = a_re - b_re;
            raw_im = a_im - b_im;
         end
         OP_MUL: begin
            raw_re = (a_re * b_re) - (a_im * b_im);
            raw_im = (a_re * b_im) + (a_im * b_re);
         end
         default: begin
            raw_re = a_re;
            raw_im = -a_im;
         end
      endcase
      sat_re = sat_half(raw_re);
      sat_im = sat_half(raw_im);
   end

   // Sequencer state and datapath registers; async active-low reset aborts any operation
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         dst_q      <= '0;
         addr_a_q   <= '0;
         addr_b_q   <= '0;
         opa_q      <= '0;
         opb_q      <= '0;
         mul_re_q   <= '0;
         mul_ovf_q  <= 1'b0;
         result_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         dst_q      <= dst_d;
         addr_a_q   <= addr_a_d;
         addr_b_q   <= addr_b_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         mul_re_q   <= mul_re_d;
         mul_ovf_q  <= mul_ovf_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
      end
   end

   // Next-state and register updates for IDLE->FETCH->LATCH->EXEC->(MUL2)->WRITE
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      dst_d      = dst_q;
      addr_a_d   = addr_a_q;
      addr_b_d   = addr_b_q;
      opa_d      = opa_q;
      opb_d      = opb_q;
      mul_re_d   = mul_re_q;
      mul_ovf_d  = mul_ovf_q;
      result_d   = result_q;
      overflow_d = overflow_q;

      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               op_d     = bus.cmd_op;
               dst_d    = bus.cmd_dst;
               addr_a_d = bus.cmd_src_a;
               addr_b_d = bus.cmd_src_b;
               state_d  = S_FETCH;
            end
         end
         S_FETCH: begin
            // Memory samples the held addresses at the end of this cycle
            state_d = S_LATCH;
         end
         S_LATCH: begin
            opa_d   = bus.mem_q_A;
            opb_d   = bus.mem_q_B;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (op_q == OP_MUL) begin
               mul_re_d  = sat_re[H-1:0];
               mul_ovf_d = sat_re[H];
               state_d   = S_MUL2;
            end else begin
               result_d   = {sat_re[H-1:0], sat_im[H-1:0]};
               overflow_d = sat_re[H] | sat_im[H];
               addr_a_d   = dst_q;
               addr_b_d   = dst_q;
               state_d    = S_WRITE;
            end
         end
         S_MUL2: begin
            result_d   = {mul_re_q, sat_im[H-1:0]};
            overflow_d = mul_ovf_q | sat_im[H];
            addr_a_d   = dst_q;
            addr_b_d   = dst_q;
            state_d    = S_WRITE;
         end
         S_WRITE: begin
            // Operands were latched earlier, so dst may alias a source safely
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs: strobes decoded from registered state, data straight from registers
   assign bus.cmd_ready     = (state_q == S_IDLE);
   assign bus.mem_write     = (state_q == S_WRITE);
   assign bus.done          = (state_q == S_WRITE);
   assign bus.mem_address_A = addr_a_q;
   assign bus.mem_address_B = addr_b_q;
   assign bus.mem_data_A    = result_q;
   assign bus.mem_data_B    = result_q;
   assign bus.result        = result_q;
   assign bus.overflow      = overflow_q;
   assign bus.state_dbg     = state_q;

endmodule
